// File: rtl/sum_pkg.sv
// sum_pkg: shared state encoding and default sizing for the serial batch summer
package sum_pkg;
   localparam int DEF_WIDTH   = 4;
   localparam int DEF_NUM_OPS = 4;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;
endpackage

// File: rtl/sum_sequencer_batch_counter.sv
// batch_counter: operands-accepted counter with clear priority and terminal-count flag
module batch_counter
   import sum_pkg::*;
#(
   parameter int NUM_OPS = DEF_NUM_OPS,
   parameter int CNT_W   = $clog2(NUM_OPS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o,
   output logic             tc_o
);
   logic [CNT_W-1:0] count_q;
   // clear wins over increment so an abort never leaves a stale count
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count_q <= '0;
      else count_q <= clr_i ? '0 : inc_i ? count_q + 1'b1 : count_q;
   assign count_o = count_q;
   assign tc_o    = count_q == CNT_W'(NUM_OPS - 1);
endmodule

// File: rtl/sum_sequencer.sv
// sum_sequencer: accumulates NUM_OPS streamed operands through one adder and holds the batch sum
module sum_sequencer
   import sum_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_OPS = DEF_NUM_OPS,
   localparam int SUM_W  = WIDTH + $clog2(NUM_OPS),
   localparam int CNT_W  = $clog2(NUM_OPS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] out_sum,
   output logic [CNT_W-1:0] op_count,
   output logic             busy
);
   state_t           state_q;
   logic [SUM_W-1:0] acc_q, sum_d, out_sum_q;
   logic             out_valid_q, accept, out_hs, tc;
   assign in_ready = state_q != ST_HOLD;
   assign busy     = state_q != ST_IDLE;
   assign accept   = in_valid & in_ready;
   assign out_hs   = out_valid_q & out_ready;
   assign sum_d    = (state_q == ST_IDLE ? '0 : acc_q) + {{(SUM_W-WIDTH){1'b0}}, in_data};
   batch_counter #(.NUM_OPS(NUM_OPS), .CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (flush | out_hs),
      .inc_i  (accept),
      .count_o(op_count),
      .tc_o   (tc)
   );
   // batch FSM; flush overrides every handshake, result registers load on the last accept
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
      end else if (flush) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (accept) begin
               acc_q   <= sum_d;
               state_q <= ST_ACCUM;
            end
            ST_ACCUM: if (accept) begin
               acc_q <= sum_d;
               if (tc) begin
                  state_q     <= ST_HOLD;
                  out_valid_q <= 1'b1;
                  out_sum_q   <= sum_d;
               end
            end
            ST_HOLD: if (out_ready) begin
               state_q     <= ST_IDLE;
               acc_q       <= '0;
               out_valid_q <= 1'b0;
               out_sum_q   <= '0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
endmodule

// File: tb/tb_sum_sequencer.sv
// tb_sum_sequencer: directed plus randomized check against an operand-list reference model
module tb_sum_sequencer;
   localparam int W = 4;
   localparam int N = 4;
   localparam int SW = W + $clog2(N);
   localparam int CW = $clog2(N + 1);

   logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready, out_valid, busy;
   logic [SW-1:0] out_sum;
   logic [CW-1:0] op_count;

   int n_tests = 0, n_fail = 0;
   int m_ops[$];
   bit m_hold = 0;
   int m_sum = 0;

   sum_sequencer #(.WIDTH(W), .NUM_OPS(N)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .op_count(op_count), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare();
      chk("in_ready", int'(in_ready), int'(!m_hold));
      chk("out_valid", int'(out_valid), int'(m_hold));
      chk("out_sum", int'(out_sum), m_hold ? m_sum : 0);
      chk("op_count", int'(op_count), m_hold ? N : m_ops.size());
      chk("busy", int'(busy), int'(m_hold || m_ops.size() != 0));
   endtask

   task automatic model_clear();
      m_ops.delete();
      m_hold = 0;
      m_sum = 0;
   endtask

   task automatic model_update(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
      if (fl) model_clear();
      else if (m_hold) begin
         if (ordy) m_hold = 0;
      end else if (v) begin
         m_ops.push_back(int'(d));
         if (m_ops.size() == N) begin
            m_hold = 1;
            m_sum = m_ops.sum();
            m_ops.delete();
         end
      end
   endtask

   task automatic step(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
      @(negedge clk);
      compare();
      in_valid = v; in_data = d; out_ready = ordy; flush = fl;
      @(posedge clk);
      model_update(v, d, ordy, fl);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int gv[7] = '{1, 0, 1, 0, 1, 0, 1};
      int gd[7] = '{3, 9, 0, 9, 7, 9, 2};
      int gc[7] = '{1, 1, 2, 2, 3, 3, 4};
      do_reset();
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_sum", int'(out_sum), 0);
      chk("rst_op_count", int'(op_count), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      // four max operands, consumer always ready
      repeat (N) step(1, 15, 1, 0);
      chk("full_valid", int'(out_valid), 1);
      chk("full_sum", int'(out_sum), 60);
      chk("full_in_ready", int'(in_ready), 0);
      step(1, 9, 1, 0);
      chk("full_idle_valid", int'(out_valid), 0);
      chk("full_idle_busy", int'(busy), 0);
      chk("full_idle_count", int'(op_count), 0);
      // consumer stalls while a new operand waits
      repeat (N) step(1, 15, 0, 0);
      repeat (5) begin
         step(1, 9, 0, 0);
         chk("stall_sum", int'(out_sum), 60);
         chk("stall_count", int'(op_count), 4);
      end
      step(1, 9, 1, 0);
      chk("stall_release_busy", int'(busy), 0);
      step(1, 9, 0, 0);
      chk("stall_next_first", int'(op_count), 1);
      step(0, 0, 0, 1);
      // gapped input
      for (int i = 0; i < 7; i++) begin
         step(gv[i][0], W'(gd[i]), 0, 0);
         chk("gap_count", int'(op_count), gc[i]);
      end
      chk("gap_sum", int'(out_sum), 12);
      step(0, 0, 1, 0);
      // flush mid-batch drops the operand presented with it
      step(1, 5, 0, 0);
      step(1, 6, 0, 0);
      step(1, 8, 0, 1);
      chk("flush_count", int'(op_count), 0);
      repeat (N) step(1, 1, 0, 0);
      chk("flush_after_sum", int'(out_sum), 4);
      step(0, 0, 1, 0);
      // flush with out_ready in HOLD discards the result
      repeat (N) step(1, 15, 0, 0);
      chk("hold_sum", int'(out_sum), 60);
      step(0, 0, 1, 1);
      chk("hold_flush_valid", int'(out_valid), 0);
      step(0, 0, 1, 0);
      chk("hold_flush_nodup", int'(out_valid), 0);
      repeat (N) step(1, 2, 0, 0);
      chk("hold_flush_next_sum", int'(out_sum), 8);
      step(0, 0, 1, 0);
      // asynchronous reset mid-batch clears without a clock edge
      step(1, 7, 0, 0);
      step(1, 7, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", int'(op_count), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_in_ready", int'(in_ready), 1);
      chk("arst_out_valid", int'(out_valid), 0);
      do_reset();
      // randomized traffic against the model
      for (int i = 0; i < 3000; i++)
         step($urandom_range(99) < 70, W'($urandom), $urandom_range(1), $urandom_range(99) < 3);
      step(0, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
